// File: rtl/stream_arb_pkg.sv
// stream_arb_pkg: shared constants, id sizing helper and id type for the stream arbiter.
package stream_arb_pkg;

    localparam int MAX_REQ = 16;

    function automatic int id_width(input int n);
        return $clog2(n);
    endfunction

    typedef logic [$clog2(MAX_REQ)-1:0] arb_id_t;

endpackage

// File: rtl/rr_prio_picker.sv
// rr_prio_picker: combinational round-robin pick; rotate requests by ptr, fixed-priority encode, rotate back.
module rr_prio_picker
    import stream_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    idx,
    output logic               any_grant
);

    logic [NUM_REQ-1:0] rot;
    logic [NUM_REQ-1:0] rot_oh;
    logic [ID_W-1:0]    enc;

    // Bit 0 of rot is the requester at ptr, so lowest set bit is the round-robin winner.
    always_comb begin
        rot = '0;
        for (int i = 0; i < NUM_REQ; i++) rot[i] = req[(i + int'(ptr)) % NUM_REQ];
    end

    always_comb begin
        enc = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) enc = rot[i] ? ID_W'(i) : enc;
    end

    assign any_grant = |rot;
    assign rot_oh    = any_grant ? NUM_REQ'(1) << enc : '0;
    assign idx       = ID_W'((int'(enc) + int'(ptr)) % NUM_REQ);

    always_comb begin
        grant = '0;
        for (int i = 0; i < NUM_REQ; i++) grant[(i + int'(ptr)) % NUM_REQ] = rot_oh[i];
    end

endmodule

// File: rtl/stream_rr_arbiter.sv
// stream_rr_arbiter: round-robin merge of NUM_REQ valid/ready streams into one registered output stage.
// Define STREAM_ARB_PKT_LOCK_EN to hold the grant from a packet's first beat until its last beat.
module stream_rr_arbiter
    import stream_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ID_W       = id_width(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          out_valid,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic                          out_last,
    output logic [ID_W-1:0]               out_id,
    input  logic                          out_ready
);

    logic                  stage_ready;
    logic                  pick_any;
    logic                  acc;
    logic                  sel_last;
    logic                  locked;
    logic [NUM_REQ-1:0]    pick_oh;
    logic [NUM_REQ-1:0]    lock_oh;
    logic [ID_W-1:0]       pick_idx;
    logic [ID_W-1:0]       gnt_idx;
    logic [ID_W-1:0]       rr_ptr;
    logic [ID_W-1:0]       nxt_ptr;
    logic [ID_W-1:0]       lock_id;
    logic [DATA_WIDTH-1:0] sel_data;

    rr_prio_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant     (pick_oh),
        .idx       (pick_idx),
        .any_grant (pick_any)
    );

    assign stage_ready = ~out_valid | out_ready;
    assign lock_oh     = NUM_REQ'(1) << lock_id;
    assign gnt_idx     = locked ? lock_id : pick_idx;
    // rst_n gates ready so nothing is offered while the block is held in reset.
    assign req_ready   = (rst_n & stage_ready & (locked | pick_any)) ? (locked ? lock_oh : pick_oh) : '0;
    assign acc         = |(req_valid & req_ready);
    assign sel_data    = req_data[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
    assign sel_last    = req_last[gnt_idx];
    assign nxt_ptr     = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_id    <= '0;
        end else if (acc) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_last  <= sel_last;
            out_id    <= gnt_idx;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef STREAM_ARB_PKT_LOCK_EN
    // The pointer only moves when a packet completes, so a whole packet counts as one turn.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr  <= '0;
            locked  <= 1'b0;
            lock_id <= '0;
        end else if (acc) begin
            locked <= ~sel_last;
            if (sel_last) rr_ptr <= nxt_ptr;
            else lock_id <= gnt_idx;
        end
    end
`else
    assign locked  = 1'b0;
    assign lock_id = '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rr_ptr <= '0;
        else if (acc) rr_ptr <= nxt_ptr;
    end
`endif

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// tb_stream_rr_arbiter: directed and random checks of stream_rr_arbiter against a per-cycle reference model.
// Follows STREAM_ARB_PKT_LOCK_EN the same way the design does.
module tb_stream_rr_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;

    logic          clk;
    logic          rst_n;
    logic [N-1:0]  req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]  req_last;
    logic [N-1:0]  req_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic [1:0]    out_id;
    logic          out_ready;

    stream_rr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_id    (out_id),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [N-1:0]  v;
    logic [N-1:0]  l;
    logic [DW-1:0] d [N];

    logic          m_valid, m_last, m_locked;
    logic [DW-1:0] m_data;
    int            m_id, m_ptr, m_lock_id;
    logic          acc_f;
    int            acc_g;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive();
        req_valid = v;
        req_last  = l;
        for (int i = 0; i < N; i++) req_data[i*DW +: DW] = d[i];
    endtask

    task automatic model_reset();
        m_valid = 0; m_last = 0; m_locked = 0; m_data = '0;
        m_id = 0; m_ptr = 0; m_lock_id = 0; acc_f = 0; acc_g = 0;
    endtask

    // Called at a falling edge: apply inputs, check against the model, then advance one clock.
    task automatic step();
        int g;
        logic any;
        logic [N-1:0] exp_rdy;
        drive();
        #1;
        g = 0;
        any = 0;
        if (m_locked) begin
            g = m_lock_id;
            any = 1;
        end else begin
            for (int k = 0; k < N; k++)
                if (!any && v[(m_ptr + k) % N]) begin
                    g = (m_ptr + k) % N;
                    any = 1;
                end
        end
        exp_rdy = (any && (!m_valid || out_ready)) ? N'(1) << g : '0;
        chk("req_ready", req_ready, exp_rdy);
        chk("onehot0", $onehot0(req_ready), 1);
        chk("out_valid", out_valid, m_valid);
        chk("out_data", out_data, m_data);
        chk("out_last", out_last, m_last);
        chk("out_id", out_id, m_id);
        acc_f = exp_rdy[g] && v[g];
        acc_g = g;
        if (acc_f) begin
            m_valid = 1;
            m_data  = d[g];
            m_last  = l[g];
            m_id    = g;
`ifdef STREAM_ARB_PKT_LOCK_EN
            if (l[g]) begin
                m_locked = 0;
                m_ptr = (g + 1) % N;
            end else begin
                m_locked = 1;
                m_lock_id = g;
            end
`else
            m_ptr = (g + 1) % N;
`endif
        end else if (m_valid && out_ready) begin
            m_valid = 0;
        end
        @(negedge clk);
    endtask

    initial begin
        int n1;
        int n3;
        rst_n = 0;
        out_ready = 1;
        v = '1;
        l = '1;
        for (int i = 0; i < N; i++) d[i] = 32'h100 + i;
        drive();
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_ready", req_ready, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_id", out_id, 0);
        rst_n = 1;

        // All requesters busy with single-beat packets: strict rotation.
        for (int k = 0; k < 8; k++) begin
            step();
            chk("t1_id", out_id, k % N);
        end

        // Requester 1 sends a 4-beat packet while requester 3 competes.
        v = 4'b1010;
        n1 = 0;
        n3 = 0;
        for (int k = 0; k < 8; k++) begin
            v[1] = (n1 < 4);
            d[1] = 32'hB0 + n1;
            l[1] = (n1 == 3);
            d[3] = 32'hC0 + n3;
            step();
            if (acc_f && acc_g == 1) n1++;
            if (acc_f && acc_g == 3) n3++;
`ifdef STREAM_ARB_PKT_LOCK_EN
            chk("t2_id", out_id, (k < 4) ? 1 : 3);
`else
            chk("t2_id", out_id, (k % 2 == 1 || k > 7) ? 3 : 1);
`endif
        end

        // Single requester streaming back-to-back.
        v = 4'b0100;
        for (int k = 0; k < 8; k++) begin
            d[2] = 32'hA0 + k;
            l[2] = (k == 7);
            step();
            chk("t3_data", out_data, 32'hA0 + k);
            chk("t3_valid", out_valid, 1);
        end

        // Back-pressure holds the stage, then drain and refill together.
        out_ready = 0;
        v = 4'b0001;
        d[0] = 32'hD0;
        l[0] = 1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("t4_hold", out_data, 32'hA7);
            chk("t4_ready", req_ready, 0);
        end
        out_ready = 1;
        step();
        chk("t4_refill", out_data, 32'hD0);
        chk("t4_valid", out_valid, 1);

        // Reset in the middle of a packet from requester 0.
        v = 4'b0100;
        d[2] = 32'hE2;
        l[2] = 1;
        step();
        v = 4'b0001;
        d[0] = 32'hE0;
        l[0] = 0;
        step();
        v = 4'b1010;
        d[1] = 32'hF1;
        d[3] = 32'hF3;
        l = '1;
        drive();
        rst_n = 0;
        #1;
        chk("t5_valid", out_valid, 0);
        chk("t5_ready", req_ready, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1;
        step();
        chk("t5_id", out_id, 1);
        chk("t5_data", out_data, 32'hF1);

        // Random traffic; a pending beat is held until accepted.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++)
                if ((acc_f && acc_g == i) || !v[i]) begin
                    v[i] = 1'($urandom_range(0, 1));
                    d[i] = $urandom;
                    l[i] = ($urandom_range(0, 2) == 0);
                end
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stream_rr_arbiter.md
Name: stream_rr_arbiter

Overview:
- Shares one registered valid/ready output stage among NUM_REQ requester streams.
- Arbitration is round-robin. With packet lock enabled, a grant is held from a packet's first beat until its last beat is accepted.
- Sits upstream of a shared datapath consumer (e.g. a DMA or egress port) and feeds it a single merged stream tagged with the source id.
- Sustains one beat per cycle when out_ready is held high.

Parameters:
- NUM_REQ, 4, number of requester streams; legal range 2 to 16.
- DATA_WIDTH, 32, payload width per beat.
- ID_W, $clog2(NUM_REQ), width of out_id; derived, must not be overridden.

Ports:
- clk  input  1  clock; all logic is rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  NUM_REQ  per-requester beat valid.
- req_data  input  NUM_REQ*DATA_WIDTH  per-requester payload; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_last  input  NUM_REQ  per-requester end-of-packet marker.
- req_ready  output  NUM_REQ  per-requester accept; at most one bit is high in any cycle.
- out_valid  output  1  registered output beat valid.
- out_data  output  DATA_WIDTH  registered payload.
- out_last  output  1  registered end-of-packet marker.
- out_id  output  ID_W  index of the requester that sourced the beat.
- out_ready  input  1  downstream accept.

Behaviour:
- Reset values: out_valid=0, out_data=0, out_last=0, out_id=0, rr_ptr=0, locked=0, lock_id=0.
- While rst_n is low, req_ready=0.
- Output stage is one register deep.
  - stage_ready = ~out_valid | out_ready.
  - Latency from input accept to out_valid is 1 cycle.
  - When the stage is full and out_ready=0, out_* hold stable.
- Grant selection is combinational and only applies when not locked.
  - Scan from index rr_ptr upward, wrapping modulo NUM_REQ.
  - The first i with req_valid[i]=1 wins.
  - If no req_valid bit is set, there is no grant and req_ready is all zero.
- When locked, grant = lock_id regardless of the other valids.
  - The lock holder deasserting req_valid mid-packet stalls the arbiter. It does not release the grant.
- req_ready[i] = (grant==i) & stage_ready. req_ready may depend on req_valid; req_valid must not depend on req_ready.
- On accept (req_valid[g] & req_ready[g]):
  - out_data, out_last and out_id load from requester g; out_valid is set to 1.
  - If req_last[g]=0: locked<=1, lock_id<=g.
  - If req_last[g]=1: locked<=0, rr_ptr <= (g+1) mod NUM_REQ.
- If no input is accepted and out_valid & out_ready, then out_valid<=0.
- Simultaneous drain and accept in the same cycle: the new beat is loaded and out_valid stays 1, giving full throughput.
- rr_ptr advances only on last-beat accepts. With no traffic it is unchanged.
- An asynchronous reset mid-packet clears the lock and the stage. The partial packet is truncated; recovery is the upstream's responsibility.
- No priority inversion: a requester with valid held high is granted within NUM_REQ packets.

Optional Feature:
- Macro: STREAM_ARB_PKT_LOCK_EN.
- Defined: packet lock behaves as described above.
- Undefined:
  - locked is tied to 0.
  - Every beat is arbitrated independently.
  - rr_ptr <= (g+1) mod NUM_REQ on every accept.
  - req_last is forwarded to out_last but has no effect on arbitration.

Decomposition:
- Package stream_arb_pkg holds:
  - MAX_REQ=16 constant.
  - Function id_width(n), returning $clog2(n).
  - Typedef arb_id_t, sized for MAX_REQ.
- Sub-module rr_prio_picker:
  - Purely combinational.
  - Inputs: req vector and rr_ptr. Outputs: one-hot grant, encoded index, any_grant.
  - Implemented by rotating the request vector by rr_ptr, applying a fixed priority encoder, then rotating back.
- The top level owns the lock state, the pointer, the output stage and the data mux.

Test Plan:
1. Reset, then req_valid=4'b1111, all last=1, out_ready=1 → out_id sequence 0,1,2,3,0,... on consecutive cycles; first out_valid appears 1 cycle after the first accept.
2. Requesters 1 and 3 both active; requester 1 sends a 4-beat packet (last on beat 4) → out_id=1 for 4 consecutive beats, then 3. With STREAM_ARB_PKT_LOCK_EN undefined: out_id alternates 1,3,1,3.
3. Single requester 2, valid held high, out_ready=1 → one beat per cycle, data 0xA0..0xA7 appear in order, no bubbles.
4. Stage full, out_ready=0 for 5 cycles → out_data stable, all req_ready=0; out_ready rises → drain and refill in the same cycle.
5. Assert rst_n low for 1 cycle mid-packet from requester 0 → out_valid=0, lock cleared; after release, requester 1 (valid) is granted first because rr_ptr=0 and requester 0 is idle.
6. Check every cycle: req_ready is onehot0, and any stable valid with no accept holds its data stable.
